// File: rtl/mfda_seq_pkg.sv
// Shared types and constants for the MFDA valve/pump sequencers.
package mfda_seq_pkg;

  localparam int CNT_W_DEF = 16;

  // Phase codes double as the externally visible phase output.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD2 = 3'd1,
    S_MIX0  = 3'd2,
    S_LOAD3 = 3'd3,
    S_MIX1  = 3'd4,
    S_FLUSH = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Actuator/status bundle driven from the current phase.
  typedef struct packed {
    logic pump_soln1;
    logic pump_soln2;
    logic pump_soln3;
    logic valve_out;
    logic done;
  } act_t;

  localparam act_t ACT_IDLE  = 5'b00000;
  localparam act_t ACT_LOAD2 = 5'b01000;
  localparam act_t ACT_MIX0  = 5'b11000;
  localparam act_t ACT_LOAD3 = 5'b00100;
  localparam act_t ACT_MIX1  = 5'b11110;
  localparam act_t ACT_FLUSH = 5'b00110;
  localparam act_t ACT_DONE  = 5'b00001;

  // Output table lookup for a phase.
  function automatic act_t act_decode(input state_t s);
    case (s)
      S_LOAD2: return ACT_LOAD2;
      S_MIX0:  return ACT_MIX0;
      S_LOAD3: return ACT_LOAD3;
      S_MIX1:  return ACT_MIX1;
      S_FLUSH: return ACT_FLUSH;
      S_DONE:  return ACT_DONE;
      default: return ACT_IDLE;
    endcase
  endfunction

  // Phase that follows a timed phase when its dwell expires.
  function automatic state_t next_phase(input state_t s);
    case (s)
      S_LOAD2: return S_MIX0;
      S_MIX0:  return S_LOAD3;
      S_LOAD3: return S_MIX1;
      S_MIX1:  return S_FLUSH;
      S_FLUSH: return S_DONE;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mfda_dwell_timer.sv
// Loadable down-counter with zero flag; never wraps below zero.
module mfda_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority over decrement; decrement is held off at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mix_1_iter_sequencer.sv
// Timed load/mix/flush sequencer for the two-stage mixing netlist.
// Handshake: start is taken only in IDLE (abort has priority there); busy is
// high in every non-IDLE phase; done and aborted are single-cycle pulses.
module mix_1_iter_sequencer
  import mfda_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] dwell_load2,
  input  logic [CNT_W-1:0] dwell_mix0,
  input  logic [CNT_W-1:0] dwell_load3,
  input  logic [CNT_W-1:0] dwell_mix1,
  input  logic [CNT_W-1:0] dwell_flush,
  output logic             pump_soln1,
  output logic             pump_soln2,
  output logic             pump_soln3,
  output logic             valve_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [2:0]       phase
);

  state_t           state, state_next, succ;
  act_t             act_q;
  logic             busy_q, aborted_q;
  logic             tmr_load, tmr_dec, tmr_zero, take_abort, capture;
  logic [CNT_W-1:0] tmr_val, shadow_sel;
  // LOAD2's dwell is consumed straight from the input at start, so only the
  // four later dwells need shadowing.
  logic [CNT_W-1:0] sh_mix0, sh_load3, sh_mix1, sh_flush;

  // A dwell of 0 behaves as 1; counter is loaded with effective dwell - 1.
  function automatic logic [CNT_W-1:0] dwell_m1(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  mfda_dwell_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Next-state, timer control and abort/capture decisions.
  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_dec    = 1'b0;
    take_abort = 1'b0;
    capture    = 1'b0;
    succ       = next_phase(state);
    case (succ)
      S_MIX0:  shadow_sel = sh_mix0;
      S_LOAD3: shadow_sel = sh_load3;
      S_MIX1:  shadow_sel = sh_mix1;
      S_FLUSH: shadow_sel = sh_flush;
      default: shadow_sel = '0;
    endcase
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_next = S_LOAD2;
          tmr_load   = 1'b1;
          tmr_val    = dwell_m1(dwell_load2);
          capture    = 1'b1;
        end
      end
      S_LOAD2, S_MIX0, S_LOAD3, S_MIX1, S_FLUSH: begin
        if (abort) begin
          state_next = S_IDLE;
          tmr_load   = 1'b1;
          take_abort = 1'b1;
        end else if (tmr_zero) begin
          state_next = succ;
          if (succ != S_DONE) begin
            tmr_load = 1'b1;
            tmr_val  = dwell_m1(shadow_sel);
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register plus outputs registered from the next phase (Moore).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      act_q     <= ACT_IDLE;
      busy_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_next;
      act_q     <= act_decode(state_next);
      busy_q    <= (state_next != S_IDLE);
      aborted_q <= take_abort;
    end
  end

  // Shadow dwells, frozen for the whole run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_mix0  <= '0;
      sh_load3 <= '0;
      sh_mix1  <= '0;
      sh_flush <= '0;
    end else if (capture) begin
      sh_mix0  <= dwell_mix0;
      sh_load3 <= dwell_load3;
      sh_mix1  <= dwell_mix1;
      sh_flush <= dwell_flush;
    end
  end

  assign pump_soln1 = act_q.pump_soln1;
  assign pump_soln2 = act_q.pump_soln2;
  assign pump_soln3 = act_q.pump_soln3;
  assign valve_out  = act_q.valve_out;
  assign done       = act_q.done;
  assign busy       = busy_q;
  assign aborted    = aborted_q;
  assign phase      = state;

endmodule

// File: tb/tb_mix_1_iter_sequencer.sv
// Scoreboard bench for mix_1_iter_sequencer: stimulus queues expected
// done/aborted pulses with their cycle; a negedge monitor pops and compares.
module tb_mix_1_iter_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] dwell_load2 = '0, dwell_mix0 = '0, dwell_load3 = '0;
  logic [15:0] dwell_mix1 = '0, dwell_flush = '0;
  logic        pump_soln1, pump_soln2, pump_soln3, valve_out;
  logic        busy, done, aborted;
  logic [2:0]  phase;

  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  logic [33:0] exp_q[$];
  logic [33:0] ev;
  logic [4:0]  exp_act;
  int          t;
  int          t2;

  mix_1_iter_sequencer #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .dwell_load2 (dwell_load2),
    .dwell_mix0  (dwell_mix0),
    .dwell_load3 (dwell_load3),
    .dwell_mix1  (dwell_mix1),
    .dwell_flush (dwell_flush),
    .pump_soln1  (pump_soln1),
    .pump_soln2  (pump_soln2),
    .pump_soln3  (pump_soln3),
    .valve_out   (valve_out),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .phase       (phase)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int eff(input logic [15:0] d);
    return (d == 16'd0) ? 1 : int'(d);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Pulse start for one cycle with the given dwells; t is the start cycle.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic [15:0] d, input logic [15:0] e, input bit exp_done,
                        output int ts);
    int dsum;
    dwell_load2 = a; dwell_mix0 = b; dwell_load3 = c; dwell_mix1 = d; dwell_flush = e;
    start = 1'b1;
    ts = cyc;
    dsum = eff(a) + eff(b) + eff(c) + eff(d) + eff(e);
    if (exp_done) exp_q.push_back({2'b10, 32'(ts + 1 + dsum)});
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: output table vs phase every cycle, and pulse scoreboard.
  always @(negedge clk) begin
    case (phase)
      3'd0:    exp_act = 5'b00000;
      3'd1:    exp_act = 5'b01000;
      3'd2:    exp_act = 5'b11000;
      3'd3:    exp_act = 5'b00100;
      3'd4:    exp_act = 5'b11110;
      3'd5:    exp_act = 5'b00110;
      3'd6:    exp_act = 5'b00001;
      default: exp_act = 5'b11111;
    endcase
    chk("out_table", {27'd0, pump_soln1, pump_soln2, pump_soln3, valve_out, done}, {27'd0, exp_act});
    chk("busy_vs_phase", {31'd0, busy}, {31'd0, (phase != 3'd0)});
    if (done || aborted) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, done, aborted}, 32'd0);
      end else begin
        ev = exp_q.pop_front();
        chk("pulse_kind", {30'd0, done, aborted}, {30'd0, ev[33:32]});
        chk("pulse_cycle", 32'(cyc), ev[31:0]);
      end
    end
  end

  // Directed stimulus
  initial begin
    @(negedge clk);
    chk("reset_phase", {29'd0, phase}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // 1: all dwells 3, D=15
    launch(16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 1'b1, t);
    chk("t1_load2_first", {29'd0, phase}, 32'd1);
    chk("t1_busy_first", {31'd0, busy}, 32'd1);
    go_to(t + 3);  chk("t1_load2_last", {29'd0, phase}, 32'd1);
    go_to(t + 4);  chk("t1_mix0_first", {29'd0, phase}, 32'd2);
    go_to(t + 13); chk("t1_flush_first", {29'd0, phase}, 32'd5);
    go_to(t + 15); chk("t1_flush_last", {29'd0, phase}, 32'd5);
    go_to(t + 16); chk("t1_done_phase", {29'd0, phase}, 32'd6);
    go_to(t + 17); chk("t1_idle_after", {29'd0, phase}, 32'd0);

    // 2: mix0 dwell 0 -> 1 cycle; abort during DONE is ignored
    step(2);
    launch(16'd2, 16'd0, 16'd2, 16'd2, 16'd2, 1'b1, t);
    go_to(t + 3);  chk("t2_mix0_one", {29'd0, phase}, 32'd2);
    go_to(t + 4);  chk("t2_load3_first", {29'd0, phase}, 32'd3);
    go_to(t + 10); chk("t2_done_phase", {29'd0, phase}, 32'd6);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t2_idle_after", {29'd0, phase}, 32'd0);

    // 3: abort two cycles into LOAD3
    step(2);
    launch(16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 1'b0, t);
    go_to(t + 8);  chk("t3_in_load3", {29'd0, phase}, 32'd3);
    abort = 1'b1;
    exp_q.push_back({2'b01, 32'(t + 9)});
    step(1);
    abort = 1'b0;
    chk("t3_idle", {29'd0, phase}, 32'd0);
    chk("t3_pumps", {28'd0, pump_soln1, pump_soln2, pump_soln3, valve_out}, 32'd0);
    go_to(t + 20); chk("t3_still_idle", {29'd0, phase}, 32'd0);

    // 4: mid-run start and dwell changes ignored; start in DONE ignored,
    // start in following IDLE cycle begins a new run
    step(2);
    launch(16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 1'b1, t);
    go_to(t + 5);
    start = 1'b1;
    dwell_load2 = 16'd1; dwell_mix0 = 16'd1; dwell_load3 = 16'd1;
    dwell_mix1 = 16'd1; dwell_flush = 16'd1;
    step(2);
    start = 1'b0;
    go_to(t + 12); chk("t4_load3_last", {29'd0, phase}, 32'd3);
    go_to(t + 17); chk("t4_flush_first", {29'd0, phase}, 32'd5);
    go_to(t + 21); chk("t4_done_phase", {29'd0, phase}, 32'd6);
    start = 1'b1;
    step(1);
    chk("t4_idle_between", {29'd0, phase}, 32'd0);
    t2 = cyc;
    exp_q.push_back({2'b10, 32'(t2 + 6)});
    step(1);
    start = 1'b0;
    chk("t4_rerun_load2", {29'd0, phase}, 32'd1);
    go_to(t2 + 7); chk("t4_rerun_idle", {29'd0, phase}, 32'd0);

    // 5: start and abort together in IDLE
    step(2);
    start = 1'b1;
    abort = 1'b1;
    step(1);
    start = 1'b0;
    abort = 1'b0;
    chk("t5_phase", {29'd0, phase}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    step(3);
    chk("t5_phase_later", {29'd0, phase}, 32'd0);

    // 6: reset mid-MIX1
    step(1);
    launch(16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 1'b0, t);
    go_to(t + 11); chk("t6_in_mix1", {29'd0, phase}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_outs", {25'd0, pump_soln1, pump_soln2, pump_soln3, valve_out, busy, done, aborted}, 32'd0);
    chk("t6_async_phase", {29'd0, phase}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("t6_idle_after", {29'd0, phase}, 32'd0);
    step(20);
    chk("t6_still_idle", {29'd0, phase}, 32'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
